// File: rtl/cla_slice_subtractor_pkg.sv
// Shared types and constants for the slice-serial
// carry-lookahead subtractor.
package cla_slice_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int idx_w(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/cla_slice_subtractor_cla_slice4.sv
// 4-bit carry-lookahead adder slice with explicit
// generate/propagate equations.
module cla_slice4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = x & y;
  assign p = x ^ y;

  assign c[0] = g[0] | (p[0] & cin);
  assign c[1] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[2] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[3] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign s    = p ^ {c[2:0], cin};
  assign cout = c[3];

endmodule

// File: rtl/cla_slice_subtractor.sv
// Multi-cycle a - b - bin, one 4-bit lookahead slice per
// clock, LSB first, with valid/ready on both sides.
module cla_slice_subtractor
  import cla_slice_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IW     = idx_w(NSLICE);

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_chk
    $error("WIDTH must be a positive multiple of 4");
  end

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;

  logic [3:0]       sx;
  logic [3:0]       sy;
  logic [3:0]       s;
  logic             cout;
  logic [WIDTH-1:0] diff_next;
  logic             last;

  // Subtract as a + ~b + ~bin through the adder slice.
  assign sx   = a_r[idx*SLICE_W +: SLICE_W];
  assign sy   = ~b_r[idx*SLICE_W +: SLICE_W];
  assign last = (idx == IW'(NSLICE - 1));

  cla_slice4 u_slice (
    .x    (sx),
    .y    (sy),
    .cin  (carry),
    .s    (s),
    .cout (cout)
  );

  always_comb begin
    diff_next = diff;
    diff_next[idx*SLICE_W +: SLICE_W] = s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= ~bin;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          diff  <= diff_next;
          carry <= cout;
          if (last) begin
            idx       <= '0;
            bout      <= ~cout;
            zero      <= (diff_next == '0);
            ovf       <= (a_r[WIDTH-1] ^ b_r[WIDTH-1])
                       & (diff_next[WIDTH-1] ^ a_r[WIDTH-1]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_slice_subtractor.sv
// Directed self-checking bench for the slice-serial
// subtractor at WIDTH=16 and WIDTH=4.
module tb_cla_slice_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  logic        in_valid4;
  logic        in_ready4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        bin4;
  logic        out_valid4;
  logic        out_ready4;
  logic [3:0]  diff4;
  logic        bout4;
  logic        ovf4;
  logic        zero4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cla_slice_subtractor #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  cla_slice_subtractor #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .a         (a4),
    .b         (b4),
    .bin       (bin4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .diff      (diff4),
    .bout      (bout4),
    .ovf       (ovf4),
    .zero      (zero4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept at edge k, expect out_valid after edge k+4.
  task automatic op16(input logic [15:0] av,
                      input logic [15:0] bv,
                      input logic        bi);
    a = av;
    b = bv;
    bin = bi;
    in_valid = 1'b1;
    chk("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = ~av;
    b = ~bv;
    bin = ~bi;
    chk("run_not_ready", in_ready, 0);
    repeat (3) begin
      tick();
      chk("lat_low", out_valid, 0);
    end
    tick();
    chk("lat_high", out_valid, 1);
  endtask

  logic [15:0] held;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    out_ready = 1'b1;
    in_valid4 = 1'b0;
    a4 = '0;
    b4 = '0;
    bin4 = 1'b0;
    out_ready4 = 1'b1;
    #12;
    chk("rst_diff", diff, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_flags", {bout, ovf, zero}, 0);
    chk("rst_iready", in_ready, 1);
    rst = 1'b0;
    tick();

    op16(16'h1234, 16'h0234, 1'b0);
    chk("t1_diff", diff, 16'h1000);
    chk("t1_flags", {bout, ovf, zero}, 3'b000);
    tick();
    chk("t1_one_cycle", out_valid, 0);
    chk("t1_idle", in_ready, 1);

    op16(16'h0000, 16'h0001, 1'b0);
    chk("t2_diff", diff, 16'hFFFF);
    chk("t2_flags", {bout, ovf, zero}, 3'b100);
    tick();

    op16(16'h8000, 16'h0001, 1'b0);
    chk("t3_diff", diff, 16'h7FFF);
    chk("t3_flags", {bout, ovf, zero}, 3'b010);
    tick();

    op16(16'h0005, 16'h0003, 1'b1);
    chk("t4_diff", diff, 16'h0001);
    chk("t4_flags", {bout, ovf, zero}, 3'b000);
    tick();

    op16(16'h0003, 16'h0003, 1'b0);
    chk("t5_diff", diff, 16'h0000);
    chk("t5_flags", {bout, ovf, zero}, 3'b001);
    tick();

    // Backpressure: result must hold while inputs churn.
    out_ready = 1'b0;
    op16(16'h1111, 16'h0101, 1'b0);
    chk("bp_diff", diff, 16'h1010);
    held = diff;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'h0F0F ^ 16'(i);
      b = 16'h3C3C + 16'(i);
      bin = i[1];
      tick();
      chk("bp_iready", in_ready, 0);
      chk("bp_ovalid", out_valid, 1);
      chk("bp_hold", diff, held);
      chk("bp_flags", {bout, ovf, zero}, 3'b000);
    end
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("bp_release", out_valid, 0);
    chk("bp_idle", in_ready, 1);
    in_valid = 1'b0;
    op16(16'h0010, 16'h0020, 1'b0);
    chk("bp_next_diff", diff, 16'hFFF0);
    chk("bp_next_flags", {bout, ovf, zero}, 3'b100);
    tick();

    // Reset in the middle of RUN with idx == 2.
    a = 16'hAAAA;
    b = 16'h1111;
    bin = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_run", out_valid, 0);
    rst = 1'b1;
    #1;
    chk("arst_ovalid", out_valid, 0);
    chk("arst_diff", diff, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("arst_iready", in_ready, 1);
    op16(16'h00FF, 16'h000F, 1'b0);
    chk("post_rst_diff", diff, 16'h00F0);
    chk("post_rst_flags", {bout, ovf, zero}, 3'b000);
    tick();

    // WIDTH=4: single slice, one-cycle latency.
    a4 = 4'h3;
    b4 = 4'h5;
    bin4 = 1'b0;
    in_valid4 = 1'b1;
    chk("w4_ready", in_ready4, 1);
    tick();
    in_valid4 = 1'b0;
    a4 = 4'hF;
    chk("w4_run", out_valid4, 0);
    tick();
    chk("w4_valid", out_valid4, 1);
    chk("w4_diff", diff4, 4'hE);
    chk("w4_flags", {bout4, ovf4, zero4}, 3'b100);
    tick();
    chk("w4_done", out_valid4, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
